// File: rtl/dca_matrix_lsu_rreq_gen_if.sv
// Command, AR and transaction-info channels of the matrix LSU read-request generator.
// The slave modport is the generator's view; master is the environment driving it.
interface dca_matrix_lsu_rreq_gen_if #(
    parameter int BW_AXI_ADDR = 32,
    parameter int BW_NUM_ROW  = 8
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [BW_AXI_ADDR-1:0]    cmd_addr;
    logic [BW_AXI_ADDR-1:0]    cmd_stride;
    logic [BW_NUM_ROW-1:0]     cmd_num_row;
    logic [7:0]                cmd_alen;
    logic                      cmd_zero;

    logic                      arvalid;
    logic                      arready;
    logic [BW_AXI_ADDR-1:0]    araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;

    logic                      txn_valid;
    logic                      txn_ready;
    logic [10+BW_AXI_ADDR-1:0] txn_info;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_stride, cmd_num_row, cmd_alen, cmd_zero,
        output cmd_ready,
        output arvalid, araddr, arlen, arsize, arburst,
        input  arready,
        output txn_valid, txn_info,
        input  txn_ready
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_stride, cmd_num_row, cmd_alen, cmd_zero,
        input  cmd_ready,
        input  arvalid, araddr, arlen, arsize, arburst,
        output arready,
        input  txn_valid, txn_info,
        output txn_ready
    );
endinterface

// File: rtl/dca_matrix_lsu_rreq_gen.sv
// Turns a strided 2-D read command into one AXI AR burst plus one txn-info record per row.
// AR and txn sides handshake independently per row; the row advances once both are done.
module dca_matrix_lsu_rreq_gen #(
    parameter int BW_AXI_ADDR      = 32,
    parameter int BW_AXI_DATA      = 32,
    parameter int MAX_NUM_AXI_DATA = 4,
    parameter int BW_NUM_ROW       = 8
) (
    input  logic                         clk,
    input  logic                         rstnn,
    input  logic                         enable,
    input  logic                         clear,
    output logic                         busy,
    dca_matrix_lsu_rreq_gen_if.slave     rreq
);
    localparam logic [7:0] ALEN_MAX = 8'(MAX_NUM_AXI_DATA - 1);
    localparam logic [2:0] ARSIZE   = 3'($clog2(BW_AXI_DATA / 8));

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    state_e                 state_q, state_d;
    logic [BW_AXI_ADDR-1:0] addr_q, addr_d;
    logic [BW_AXI_ADDR-1:0] stride_q, stride_d;
    logic [BW_NUM_ROW-1:0]  num_row_q, num_row_d;
    logic [BW_NUM_ROW-1:0]  cnt_q, cnt_d;
    logic [7:0]             alen_q, alen_d;
    logic                   zero_q, zero_d;
    logic                   ar_done_q, ar_done_d;
    logic                   txn_done_q, txn_done_d;

    logic issue;
    logic is_last;
    logic ar_hs;
    logic txn_hs;
    logic ar_side_done;
    logic advance;

    assign issue   = (state_q == ISSUE);
    assign is_last = issue && (cnt_q == num_row_q);

    // Valids are gated by enable so no handshake can happen while the state is frozen.
    assign rreq.cmd_ready = enable && !issue;
    assign rreq.arvalid   = enable && issue && !ar_done_q && !zero_q;
    assign rreq.txn_valid = enable && issue && !txn_done_q;
    assign rreq.araddr    = addr_q;
    assign rreq.arlen     = alen_q;
    assign rreq.arsize    = ARSIZE;
    assign rreq.arburst   = 2'b01;
    assign rreq.txn_info  = {is_last, zero_q, alen_q, addr_q};
    assign busy           = issue;

    assign ar_hs  = rreq.arvalid && rreq.arready;
    assign txn_hs = rreq.txn_valid && rreq.txn_ready;

    // Zero-fill rows never issue AR, so the AR side counts as already done.
    assign ar_side_done = ar_done_q || zero_q;
    assign advance      = (ar_side_done && txn_done_q) ||
                          (ar_side_done && txn_hs) ||
                          (txn_done_q && ar_hs);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        num_row_d  = num_row_q;
        cnt_d      = cnt_q;
        alen_d     = alen_q;
        zero_d     = zero_q;
        ar_done_d  = ar_done_q;
        txn_done_d = txn_done_q;

        if (enable) begin
            if (clear) begin
                state_d    = IDLE;
                cnt_d      = '0;
                ar_done_d  = 1'b0;
                txn_done_d = 1'b0;
            end else if (!issue) begin
                if (rreq.cmd_valid) begin
                    state_d    = ISSUE;
                    addr_d     = rreq.cmd_addr;
                    stride_d   = rreq.cmd_stride;
                    num_row_d  = rreq.cmd_num_row;
                    alen_d     = (rreq.cmd_alen > ALEN_MAX) ? ALEN_MAX : rreq.cmd_alen;
                    zero_d     = rreq.cmd_zero;
                    cnt_d      = '0;
                    ar_done_d  = 1'b0;
                    txn_done_d = 1'b0;
                end
            end else if (advance) begin
                ar_done_d  = 1'b0;
                txn_done_d = 1'b0;
                if (is_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    addr_d = addr_q + stride_q;
                end
            end else begin
                if (ar_hs) begin
                    ar_done_d = 1'b1;
                end
                if (txn_hs) begin
                    txn_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            stride_q   <= '0;
            num_row_q  <= '0;
            cnt_q      <= '0;
            alen_q     <= '0;
            zero_q     <= 1'b0;
            ar_done_q  <= 1'b0;
            txn_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            num_row_q  <= num_row_d;
            cnt_q      <= cnt_d;
            alen_q     <= alen_d;
            zero_q     <= zero_d;
            ar_done_q  <= ar_done_d;
            txn_done_q <= txn_done_d;
        end
    end
endmodule

// File: tb/tb_dca_matrix_lsu_rreq_gen.sv
// Self-checking bench: directed command table, hand sequences for stalls/clear/reset/enable,
// and random commands scored against a per-row expectation queue built from the command.
module tb_dca_matrix_lsu_rreq_gen;
    localparam int A    = 32;
    localparam int MAXB = 4;

    logic clk;
    logic rstnn;
    logic enable;
    logic clear;
    logic busy;

    dca_matrix_lsu_rreq_gen_if #(.BW_AXI_ADDR(A), .BW_NUM_ROW(8)) bus ();

    dca_matrix_lsu_rreq_gen #(
        .BW_AXI_ADDR(A),
        .BW_AXI_DATA(32),
        .MAX_NUM_AXI_DATA(MAXB),
        .BW_NUM_ROW(8)
    ) dut (
        .clk(clk),
        .rstnn(rstnn),
        .enable(enable),
        .clear(clear),
        .busy(busy),
        .rreq(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] stride;
        logic [7:0]  nrow;
        logic [7:0]  alen;
        logic        zero;
        int          exp_busy;
        int          exp_ar;
        int          exp_txn;
        logic [31:0] exp_last_addr;
        logic [7:0]  exp_alen;
    } vec_t;

    ar_exp_t      exp_ar[$];
    logic [41:0]  exp_txn[$];
    ar_exp_t      ar_e;
    logic [41:0]  txn_e;

    int n_chk = 0;
    int n_pass = 0;
    int cnt_ar, cnt_txn, busy_cyc;
    logic [41:0] last_txn_info;
    int rdy_mode;

    logic        prev_ar_pend, prev_txn_pend;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    logic [41:0] prev_info;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: begin bus.arready = 1'b1; bus.txn_ready = 1'b1; end
            1: begin
                bus.arready   = 1'($urandom_range(0, 1));
                bus.txn_ready = 1'($urandom_range(0, 1));
            end
            default: ;
        endcase
    endtask

    // Expected per-row traffic from the command alone: address = base + r*stride mod 2^32.
    task automatic send_cmd(input logic [31:0] a, input logic [31:0] s, input logic [7:0] n,
                            input logic [7:0] l, input logic z);
        logic [7:0]  cl;
        logic [31:0] ra;
        ar_exp_t     e;
        int          w;
        cl = (l > 8'(MAXB - 1)) ? 8'(MAXB - 1) : l;
        for (int r = 0; r <= int'(n); r++) begin
            ra = a + 32'(r) * s;
            if (!z) begin
                e.addr = ra;
                e.len  = cl;
                exp_ar.push_back(e);
            end
            exp_txn.push_back({(r == int'(n)), z, cl, ra});
        end
        cnt_ar = 0;
        cnt_txn = 0;
        busy_cyc = 0;
        bus.cmd_addr = a;
        bus.cmd_stride = s;
        bus.cmd_num_row = n;
        bus.cmd_alen = l;
        bus.cmd_zero = z;
        bus.cmd_valid = 1'b1;
        w = 0;
        while (!bus.cmd_ready && w < 50) begin
            tick();
            w++;
        end
        chk("cmd_ready_before_fire", 64'(bus.cmd_ready), 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while (busy && w < budget) begin
            tick();
            w++;
        end
        chk("idle_within_budget", 64'(busy), 0);
    endtask

    task automatic chk_drained();
        chk("ar_queue_drained", 64'(exp_ar.size()), 0);
        chk("txn_queue_drained", 64'(exp_txn.size()), 0);
    endtask

    // Row-0 handshakes done with both readies high, then stall so row 1 is pending.
    task automatic reach_row1(input logic [31:0] row1_addr);
        int w;
        rdy_mode = 2;
        bus.arready = 1'b1;
        bus.txn_ready = 1'b1;
        send_cmd(32'h6000, 32'h80, 8'd3, 8'd1, 1'b0);
        w = 0;
        while (cnt_txn < 1 && w < 20) begin
            tick();
            w++;
        end
        bus.arready = 1'b0;
        bus.txn_ready = 1'b0;
        tick();
        chk("row1_arvalid", 64'(bus.arvalid), 1);
        chk("row1_araddr", 64'(bus.araddr), 64'(row1_addr));
    endtask

    always @(negedge clk) begin
        if (rstnn) begin
            if (busy) busy_cyc++;
            if (bus.arvalid && bus.arready) begin
                cnt_ar++;
                chk("ar_expected", 64'(exp_ar.size() > 0), 1);
                if (exp_ar.size() > 0) begin
                    ar_e = exp_ar.pop_front();
                    chk("araddr", 64'(bus.araddr), 64'(ar_e.addr));
                    chk("arlen", 64'(bus.arlen), 64'(ar_e.len));
                end
                chk("arsize", 64'(bus.arsize), 2);
                chk("arburst", 64'(bus.arburst), 1);
            end
            if (bus.txn_valid && bus.txn_ready) begin
                cnt_txn++;
                last_txn_info = bus.txn_info;
                chk("txn_expected", 64'(exp_txn.size() > 0), 1);
                if (exp_txn.size() > 0) begin
                    txn_e = exp_txn.pop_front();
                    chk("txn_info", 64'(bus.txn_info), 64'(txn_e));
                end
            end
            if (enable && !clear && prev_ar_pend) begin
                chk("ar_hold_valid", 64'(bus.arvalid), 1);
                chk("ar_hold_payload", {24'd0, bus.arlen, bus.araddr}, {24'd0, prev_arlen, prev_araddr});
            end
            if (enable && !clear && prev_txn_pend) begin
                chk("txn_hold_valid", 64'(bus.txn_valid), 1);
                chk("txn_hold_payload", 64'(bus.txn_info), 64'(prev_info));
            end
            prev_ar_pend  = enable && !clear && bus.arvalid && !bus.arready;
            prev_txn_pend = enable && !clear && bus.txn_valid && !bus.txn_ready;
            prev_araddr   = bus.araddr;
            prev_arlen    = bus.arlen;
            prev_info     = bus.txn_info;
        end else begin
            prev_ar_pend  = 1'b0;
            prev_txn_pend = 1'b0;
        end
    end

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_1000, 32'h40,  8'd2, 8'd3,  1'b0, 6, 3, 3, 32'h0000_1080, 8'd3};
        vecs[1] = '{32'h0000_2000, 32'h10,  8'd1, 8'd0,  1'b1, 2, 0, 2, 32'h0000_2010, 8'd0};
        vecs[2] = '{32'h0000_3000, 32'h100, 8'd0, 8'd15, 1'b0, 2, 1, 1, 32'h0000_3000, 8'd3};
        vecs[3] = '{32'hFFFF_FFC0, 32'h40,  8'd1, 8'd1,  1'b0, 4, 2, 2, 32'h0000_0000, 8'd1};
        vecs[4] = '{32'h0000_4000, 32'h0,   8'd3, 8'd2,  1'b0, 8, 4, 4, 32'h0000_4000, 8'd2};
        vecs[5] = '{32'h0000_5000, 32'h20,  8'd0, 8'd7,  1'b1, 1, 0, 1, 32'h0000_5000, 8'd3};

        rstnn = 1'b0;
        enable = 1'b0;
        clear = 1'b0;
        rdy_mode = 2;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_stride = '0;
        bus.cmd_num_row = '0;
        bus.cmd_alen = '0;
        bus.cmd_zero = 1'b0;
        bus.arready = 1'b0;
        bus.txn_ready = 1'b0;
        prev_ar_pend = 1'b0;
        prev_txn_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready_disabled", 64'(bus.cmd_ready), 0);
        chk("rst_arvalid", 64'(bus.arvalid), 0);
        chk("rst_txn_valid", 64'(bus.txn_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_araddr", 64'(bus.araddr), 0);
        chk("rst_arlen", 64'(bus.arlen), 0);
        chk("rst_txn_info", 64'(bus.txn_info), 0);
        chk("arsize_const", 64'(bus.arsize), 2);
        chk("arburst_const", 64'(bus.arburst), 1);
        enable = 1'b1;
        #1;
        chk("rst_cmd_ready_enabled", 64'(bus.cmd_ready), 1);
        tick();
        rstnn = 1'b1;
        tick();

        rdy_mode = 0;
        for (int i = 0; i < 6; i++) begin
            send_cmd(vecs[i].addr, vecs[i].stride, vecs[i].nrow, vecs[i].alen, vecs[i].zero);
            wait_idle(100);
            chk("vec_busy_cycles", 64'(busy_cyc), 64'(vecs[i].exp_busy));
            chk("vec_ar_count", 64'(cnt_ar), 64'(vecs[i].exp_ar));
            chk("vec_txn_count", 64'(cnt_txn), 64'(vecs[i].exp_txn));
            chk("vec_last_row_addr", 64'(last_txn_info[31:0]), 64'(vecs[i].exp_last_addr));
            chk("vec_txn_alen", 64'(last_txn_info[39:32]), 64'(vecs[i].exp_alen));
            chk("vec_cmd_ready_after", 64'(bus.cmd_ready), 1);
            chk_drained();
            tick();
        end

        // txn side stalls on row 0: only one AR may go out meanwhile.
        rdy_mode = 2;
        bus.arready = 1'b1;
        bus.txn_ready = 1'b0;
        send_cmd(32'h1000, 32'h40, 8'd2, 8'd3, 1'b0);
        repeat (5) tick();
        chk("stall_ar_count", 64'(cnt_ar), 1);
        chk("stall_arvalid_low", 64'(bus.arvalid), 0);
        chk("stall_txn_valid", 64'(bus.txn_valid), 1);
        chk("stall_araddr_row0", 64'(bus.araddr), 64'h1000);
        bus.txn_ready = 1'b1;
        rdy_mode = 0;
        wait_idle(100);
        chk("stall_ar_total", 64'(cnt_ar), 3);
        chk_drained();
        tick();

        // enable low freezes the burst mid-flight.
        send_cmd(32'h7000, 32'h8, 8'd2, 8'd0, 1'b0);
        tick();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_arvalid", 64'(bus.arvalid), 0);
            chk("hold_txn_valid", 64'(bus.txn_valid), 0);
            chk("hold_busy", 64'(busy), 1);
            chk("hold_cmd_ready", 64'(bus.cmd_ready), 0);
            tick();
        end
        enable = 1'b1;
        wait_idle(100);
        chk_drained();
        tick();

        // Synchronous clear with row 1 pending.
        reach_row1(32'h6080);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_arvalid", 64'(bus.arvalid), 0);
        chk("clear_txn_valid", 64'(bus.txn_valid), 0);
        chk("clear_busy", 64'(busy), 0);
        chk("clear_cmd_ready", 64'(bus.cmd_ready), 1);
        exp_ar.delete();
        exp_txn.delete();
        rdy_mode = 0;
        send_cmd(32'h8000, 32'h40, 8'd1, 8'd2, 1'b0);
        wait_idle(100);
        chk("post_clear_ar_count", 64'(cnt_ar), 2);
        chk_drained();
        tick();

        // Asynchronous reset with row 1 pending.
        reach_row1(32'h6080);
        rstnn = 1'b0;
        #1;
        chk("arst_arvalid", 64'(bus.arvalid), 0);
        chk("arst_txn_valid", 64'(bus.txn_valid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_araddr", 64'(bus.araddr), 0);
        chk("arst_txn_info", 64'(bus.txn_info), 0);
        exp_ar.delete();
        exp_txn.delete();
        tick();
        rstnn = 1'b1;
        rdy_mode = 0;
        tick();
        send_cmd(32'h9000, 32'h100, 8'd2, 8'd1, 1'b0);
        wait_idle(100);
        chk("post_rst_txn_count", 64'(cnt_txn), 3);
        chk_drained();
        tick();

        // Random commands under random backpressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] n;
            n = 8'($urandom_range(0, 5));
            send_cmd($urandom, $urandom, n, 8'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            wait_idle(500);
            chk("rand_txn_count", 64'(cnt_txn), 64'(int'(n) + 1));
            chk_drained();
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dca_matrix_lsu_rreq_gen.md
DCA_MATRIX_LSU_RREQ_GEN -- requirements
Module: dca_matrix_lsu_rreq_gen

Interface
REQ-001 SHALL have parameter BW_AXI_ADDR, default 32, AXI address width.
REQ-002 SHALL have parameter BW_AXI_DATA, default 32, AXI data width; arsize derives from it.
REQ-003 SHALL have parameter MAX_NUM_AXI_DATA, default 4, maximum beats per row burst.
REQ-004 SHALL have parameter BW_NUM_ROW, default 8, width of the row-count field.
REQ-005 SHALL have port clk input 1: the only clock; rstnn input 1: asynchronous, active-low reset.
REQ-006 SHALL have ports enable input 1: global advance gate; clear input 1: synchronous abort.
REQ-007 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-008 SHALL have ports cmd_addr input BW_AXI_ADDR, cmd_stride input BW_AXI_ADDR, cmd_num_row input BW_NUM_ROW (rows minus one), cmd_alen input 8 (beats minus one), cmd_zero input 1 (zero-fill, no AXI).
REQ-009 SHALL have ports arvalid output 1, arready input 1, araddr output BW_AXI_ADDR, arlen output 8, arsize output 3, arburst output 2.
REQ-010 SHALL have ports txn_valid output 1, txn_ready input 1, txn_info output 10+BW_AXI_ADDR packed {is_last, is_zero, alen[7:0], row_addr}.
REQ-011 SHALL have port busy output 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE and ISSUE; all registers hold their value while enable=0.
REQ-013 In IDLE, cmd_ready SHALL equal enable; a command fires on cmd_valid&cmd_ready and latches addr, stride, num_row, clamped alen, zero; next state ISSUE.
REQ-014 alen SHALL be clamped to MAX_NUM_AXI_DATA-1 when cmd_alen exceeds it.
REQ-015 Row address SHALL start at cmd_addr and increase by stride per row, wrapping modulo 2^BW_AXI_ADDR; row counter counts 0..num_row.
REQ-016 In ISSUE, arvalid SHALL be high for the current row until its AR handshake, unless zero mode (then arvalid stays 0).
REQ-017 In ISSUE, txn_valid SHALL be high for the current row until its txn handshake; is_last=1 only when row counter equals num_row.
REQ-018 AR and txn handshakes per row SHALL complete independently via ar_done/txn_done flags, in either order or the same cycle; a completed side deasserts its valid.
REQ-019 The row SHALL advance in the cycle both sides are done (or done-flag plus concurrent handshake); flags clear, address and counter update, next row's valids assert the following cycle.
REQ-020 After the last row advances, state SHALL return to IDLE; cmd_ready reasserts the next cycle (no back-to-back acceptance in the advancing cycle).
REQ-021 araddr/arlen/txn_info SHALL stay stable while their valid is high and unhandshaken.
REQ-022 arsize SHALL equal log2(BW_AXI_DATA/8); arburst SHALL be 2'b01 (INCR) constantly.
REQ-023 4KB-boundary crossing SHALL NOT be checked; software guarantees legal bursts.
REQ-024 clear=1 (with enable) SHALL force IDLE, drop valids and done flags next cycle, and take priority over any handshake in that cycle.

Reset
REQ-025 On rstnn=0: state IDLE, arvalid=0, txn_valid=0, busy=0, araddr=0, arlen=0, txn_info=0, done flags 0, row counter 0; cmd_ready=0 while enable=0.
REQ-026 Reset mid-burst SHALL abandon the command with no further AR or txn outputs.

Verification
REQ-027 cmd addr=0x1000 stride=0x40 num_row=2 alen=3, arready/txn_ready=1 -> AR at 0x1000,0x1040,0x1080 arlen=3, txn is_last only on third, busy 6 cycles.
REQ-028 Same command, txn_ready delayed 5 cycles on row 0 -> single AR for row 0, no row-1 AR until txn handshake, araddr stable.
REQ-029 cmd_zero=1 num_row=1 -> arvalid never high, two txns with is_zero=1, last has is_last=1.
REQ-030 cmd_alen=15 with MAX_NUM_AXI_DATA=4 -> arlen=3 and txn alen=3.
REQ-031 addr=0xFFFFFFC0 stride=0x40 num_row=1 -> second araddr=0x00000000.
REQ-032 clear during row 1 with arvalid high; separately rstnn low mid-burst -> valids 0 next cycle/immediately, IDLE, new command accepted cleanly.
